midi_message_decoder: RTL

Byte-level MIDI protocol decoder. It sits between the 31250-baud UART receiver and the voice allocator / parameter registers. It consumes received bytes, tracks running status, and emits one `MIDI::note_change_t` or one `MIDI::control_change_t` per completed channel message. Messages on other channels, unsupported message types, system/SysEx traffic and unknown controllers are filtered out.

---
 rtl/midi_message_decoder_pkg.sv | 67 ++++++
 rtl/midi_message_decoder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/midi_message_decoder_pkg.sv
// MIDI protocol types shared by the UART front end, the message decoder and the voice logic.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package MIDI;

  // Bit 7 of every received byte tells status bytes apart from data bytes.
  typedef enum logic {
    DATA_BYTE   = 1'b0,
    STATUS_BYTE = 1'b1
  } byte_type_t;

  // Upper nibble of a channel status byte.
  typedef enum logic [3:0] {
    NOTE_OFF         = 4'h8,
    NOTE_ON          = 4'h9,
    POLY_PRESSURE    = 4'hA,
    CONTROL_CHANGE   = 4'hB,
    PROGRAM_CHANGE   = 4'hC,
    CHANNEL_PRESSURE = 4'hD,
    PITCH_BEND       = 4'hE
  } message_type_t;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } note_status_t;

  // Controller numbers the synth parameter registers respond to.
  typedef enum logic [6:0] {
    WAVEFORM = 7'd21,
    DETUNE   = 7'd22,
    ATTACK   = 7'd24,
    DECAY    = 7'd25,
    SUSTAIN  = 7'd26,
    RELEASE  = 7'd27,
    VOLUME   = 7'd28
  } controller_t;

  typedef struct packed {
    note_status_t status;
    logic [6:0]   note;
    logic [6:0]   velocity;
  } note_change_t;

  typedef struct packed {
    controller_t controller;
    logic [6:0]  value;
  } control_change_t;

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    WAIT_D1   = 2'd1,
    WAIT_D2   = 2'd2,
    SKIP      = 2'd3
  } decoder_state_t;

  localparam logic [3:0] SYSTEM_PREFIX = 4'hF;
  localparam logic [7:0] REALTIME_MIN  = 8'hF8;

  function automatic logic is_known_controller(input logic [6:0] num);
    case (num)
      7'd21, 7'd22, 7'd24, 7'd25, 7'd26, 7'd27, 7'd28: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/midi_message_decoder.sv
// Byte-level MIDI decoder: running status, channel filter, note and control-change extraction.
// Latency: valid pulse is registered, high for one cycle after the edge sampling the completing byte.
// Backpressure: none; every byte_valid strobe is consumed and every pulse must be taken downstream.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   byte_valid/data   one strobe per received UART byte
//   note_valid/change one-cycle pulse with {status, note, velocity}
//   cc_valid/control_change  one-cycle pulse with {controller, value}
//   channel           channel of the last emitted message (held between pulses)
module midi_message_decoder
  import MIDI::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                byte_valid,
  input  logic [7:0]                          byte_data,
  output logic                                note_valid,
  output logic [$bits(note_change_t)-1:0]     note_change,
  output logic                                cc_valid,
  output logic [$bits(control_change_t)-1:0]  control_change,
  output logic [3:0]                          channel
);

  decoder_state_t  state_q, state_d;
  logic [3:0]      run_type_q, run_type_d;
  logic [3:0]      run_chan_q, run_chan_d;
  logic [6:0]      d1_q, d1_d;
  logic            expect2_q, expect2_d;
  logic            note_valid_q, note_valid_d;
  logic            cc_valid_q, cc_valid_d;
  note_change_t    note_q, note_d;
  control_change_t cc_q, cc_d;
  logic [3:0]      chan_q, chan_d;

  // Completed-message strobe and its data bytes, valid only in the cycle of completion.
  logic            msg_done;
  logic [6:0]      msg_d1;
  logic [6:0]      msg_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= NO_STATUS;
      run_type_q   <= '0;
      run_chan_q   <= '0;
      d1_q         <= '0;
      expect2_q    <= 1'b0;
      note_valid_q <= 1'b0;
      cc_valid_q   <= 1'b0;
      note_q       <= '0;
      cc_q         <= '0;
      chan_q       <= '0;
    end else begin
      state_q      <= state_d;
      run_type_q   <= run_type_d;
      run_chan_q   <= run_chan_d;
      d1_q         <= d1_d;
      expect2_q    <= expect2_d;
      note_valid_q <= note_valid_d;
      cc_valid_q   <= cc_valid_d;
      note_q       <= note_d;
      cc_q         <= cc_d;
      chan_q       <= chan_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    run_type_d   = run_type_q;
    run_chan_d   = run_chan_q;
    d1_d         = d1_q;
    expect2_d    = expect2_q;
    note_valid_d = 1'b0;
    cc_valid_d   = 1'b0;
    note_d       = note_q;
    cc_d         = cc_q;
    chan_d       = chan_q;
    msg_done     = 1'b0;
    msg_d1       = d1_q;
    msg_d2       = '0;

    if (byte_valid) begin
      if (byte_data[7] == STATUS_BYTE) begin
        if (byte_data >= REALTIME_MIN) begin
          // Real-time bytes may interleave anywhere; the parse is left untouched.
        end else if (byte_data[7:4] == SYSTEM_PREFIX) begin
          run_type_d = '0;
          run_chan_d = '0;
          state_d    = SKIP;
        end else begin
          // A new channel status always restarts parsing, dropping any partial message.
          run_type_d = byte_data[7:4];
          run_chan_d = byte_data[3:0];
          expect2_d  = !((byte_data[7:4] == PROGRAM_CHANGE) ||
                         (byte_data[7:4] == CHANNEL_PRESSURE));
          state_d    = WAIT_D1;
        end
      end else begin
        case (state_q)
          WAIT_D1: begin
            d1_d = byte_data[6:0];
            if (expect2_q) begin
              state_d = WAIT_D2;
            end else begin
              msg_done = 1'b1;
              msg_d1   = byte_data[6:0];
            end
          end
          WAIT_D2: begin
            msg_done = 1'b1;
            msg_d1   = d1_q;
            msg_d2   = byte_data[6:0];
            state_d  = WAIT_D1;  // running status: next data byte starts a new message
          end
          default: ;
        endcase
      end
    end

    if (msg_done && (OMNI || (run_chan_q == CHANNEL))) begin
      case (run_type_q)
        NOTE_ON, NOTE_OFF: begin
          note_valid_d    = 1'b1;
          // Note-on with zero velocity is the common note-off idiom.
          note_d.status   = ((run_type_q == NOTE_ON) && (msg_d2 != 7'd0)) ? ON : OFF;
          note_d.note     = msg_d1;
          note_d.velocity = msg_d2;
          chan_d          = run_chan_q;
        end
        CONTROL_CHANGE: begin
          if (is_known_controller(msg_d1)) begin
            cc_valid_d      = 1'b1;
            cc_d.controller = controller_t'(msg_d1);
            cc_d.value      = msg_d2;
            chan_d          = run_chan_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign note_valid     = note_valid_q;
  assign note_change    = note_q;
  assign cc_valid       = cc_valid_q;
  assign control_change = cc_q;
  assign channel        = chan_q;

endmodule
